bcd_timer_core: RTL

Parametrised successor to the fixed four-digit timer datapath/controller pair: one block holding the tick prescaler, start/stop/lap edge detection, run-state FSM and an N-digit BCD counter. It supports four count modes, optional auto-reload, a lap-freeze display copy and a one-cycle `done` pulse. It sits between the button synchronisers and `display_mux`. `disp` feeds the mux digits directly.

---
 rtl/bcd_timer_core.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: stopwatch/timer core. It holds the tick prescaler,
// start/stop and lap edge detection, the IDLE/RUN/PAUSE/DONE controller and
// an N-digit BCD counter. The counter has four count modes, optional
// auto-reload, a lap-freeze display copy and a one-cycle done pulse.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   startstop, lap    synchronised button levels; a rising edge is a command
//   mode              00 up from 0, 01 up from preset, 10 down from all-9s,
//                     11 down from preset (sampled only in IDLE)
//   preset            BCD start value, digit 0 in [3:0]; digits > 9 clamp to 9
//   count             live BCD count
//   disp              registered count, or the frozen lap copy while lap_active
//   running           high while in RUN
//   lap_active        lap freeze in effect
//   done              one-cycle pulse when the terminal value is reached
module bcd_timer_core #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1_000_000,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startstop,
  input  logic                    lap,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] disp,
  output logic                    running,
  output logic                    lap_active,
  output logic                    done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;
  localparam bcd_t ALL9 = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i] == 4'd9) r[i] = 4'd0;
        else begin
          r[i] = v[i] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[i] == 4'd0) r[i] = 4'd9;
        else begin
          r[i] = v[i] - 4'd1;
          b    = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Registers
  state_e          state_q, state_d;
  logic            ss_s_q, ss_h_q, lp_s_q, lp_h_q;
  // Only the count direction survives IDLE; the start value itself is kept
  // in start_q for auto-reload.
  logic            down_q, down_d;
  bcd_t            start_q, start_d;
  bcd_t            count_q, count_d;
  bcd_t            lap_q, lap_d;
  bcd_t            disp_q, disp_d;
  logic            lap_act_q, lap_act_d;
  logic            done_q, done_d;
  logic [PW-1:0]   psc_q, psc_d;

  // Combinational helpers
  bcd_t preset_b, preset_c, start_in, term_in, term_q, stepped;
  logic ss_edge, lp_edge, step;

  assign preset_b = preset;
  assign ss_edge  = ss_s_q & ~ss_h_q;
  assign lp_edge  = lp_s_q & ~lp_h_q;
  assign step     = (psc_q == PSC_MAX);
  assign term_in  = mode[1] ? '0 : ALL9;
  assign term_q   = down_q ? '0 : ALL9;
  assign stepped  = down_q ? bcd_dec(count_q) : bcd_inc(count_q);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      preset_c[i] = (preset_b[i] > 4'd9) ? 4'd9 : preset_b[i];
  end

  always_comb begin
    case (mode)
      2'b00:   start_in = '0;
      2'b10:   start_in = ALL9;
      default: start_in = preset_c;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    down_d    = down_q;
    start_d   = start_q;
    count_d   = count_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    psc_d     = psc_q;
    done_d    = 1'b0;
    disp_d    = lap_act_q ? lap_q : count_q;

    // Lap toggles use the pre-step count when a step lands the same cycle.
    if ((state_q == S_RUN || state_q == S_PAUSE) && lp_edge) begin
      lap_act_d = ~lap_act_q;
      if (!lap_act_q) lap_d = count_q;
    end

    case (state_q)
      S_IDLE: begin
        down_d    = mode[1];
        start_d   = start_in;
        count_d   = start_in;
        lap_act_d = 1'b0;
        if (ss_edge) begin
          psc_d = '0;
          if (start_in == term_in) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (step) begin
          psc_d = '0;
          // Auto-reload: the step after reaching terminal reloads instead.
          if (AUTO_RELOAD != 0 && count_q == term_q) begin
            count_d = start_q;
          end else begin
            count_d = stepped;
            if (stepped == term_q) begin
              done_d = 1'b1;
              if (AUTO_RELOAD == 0) state_d = S_DONE;
            end
          end
        end else begin
          psc_d = psc_q + PW'(1);
        end
        // A terminal stop outranks a pause request in the same cycle.
        if (ss_edge && state_d == S_RUN) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (ss_edge) state_d = S_RUN;
      end
      S_DONE: begin
        if (ss_edge) begin
          state_d   = S_IDLE;
          lap_act_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      // History at 1: a button held through reset yields no edge.
      ss_s_q    <= 1'b1;
      ss_h_q    <= 1'b1;
      lp_s_q    <= 1'b1;
      lp_h_q    <= 1'b1;
      down_q    <= 1'b0;
      start_q   <= '0;
      count_q   <= '0;
      lap_q     <= '0;
      disp_q    <= '0;
      lap_act_q <= 1'b0;
      done_q    <= 1'b0;
      psc_q     <= '0;
    end else begin
      state_q   <= state_d;
      ss_s_q    <= startstop;
      ss_h_q    <= ss_s_q;
      lp_s_q    <= lap;
      lp_h_q    <= lp_s_q;
      down_q    <= down_d;
      start_q   <= start_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      lap_act_q <= lap_act_d;
      done_q    <= done_d;
      psc_q     <= psc_d;
    end
  end

  assign count      = count_q;
  assign disp       = disp_q;
  assign running    = (state_q == S_RUN);
  assign lap_active = lap_act_q;
  assign done       = done_q;

endmodule
